// File: rtl/wishbone_single_master.sv
// Single-transfer Wishbone classic-cycle initiator: one command in, one response out,
// with err/ack/rty termination handling, bounded retry and a no-response timeout.
module wishbone_single_master #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_wr_i,
    input  logic [15:0] cmd_adr_i,
    input  logic [7:0]  cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        wr_o,
    output logic [15:0] adr_o,
    output logic [7:0]  dat_o,
    input  logic [7:0]  dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 16;
    localparam int unsigned RW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_ERR        = 2'b01;
    localparam logic [1:0] ST_TIMEOUT    = 2'b10;
    localparam logic [1:0] ST_RETRY_FAIL = 2'b11;

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [1:0]    state_q, state_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]    rsp_status_q, rsp_status_d;
    logic          cyc_q, cyc_d;
    logic          rsp_valid_q, rsp_valid_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            retry_q      <= '0;
            tmo_q        <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            cyc_q        <= cyc_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Next-state and datapath; bus and response strobes are registered from the next state.
    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    wr_d    = cmd_wr_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (err_i) begin
                    rsp_status_d = ST_ERR;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                end else if (ack_i) begin
                    rsp_status_d = ST_OK;
                    rsp_dat_d    = wr_q ? '0 : dat_i;
                    state_d      = S_RESP;
                end else if (rty_i) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_GAP;
                    end else begin
                        rsp_status_d = ST_RETRY_FAIL;
                        rsp_dat_d    = '0;
                        state_d      = S_RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    rsp_status_d = ST_TIMEOUT;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                tmo_d   = '0;
                state_d = S_BUS;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cyc_d       = (state_d == S_BUS);
        rsp_valid_d = (state_d == S_RESP);
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign wr_o         = wr_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_wishbone_single_master.sv
// Randomized scoreboard bench for wishbone_single_master: a scripted slave answers each
// bus attempt, a high-level model predicts status/data/timing, a monitor checks responses.
module tb_wishbone_single_master;
    localparam int TO = 5;
    localparam int MR = 3;
    localparam int NATT = MR + 1;

    // slave script term codes
    localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_NONE = 3, T_BOTH = 4;

    typedef struct {
        logic [1:0] st;
        logic [7:0] dat;
        int         stb;
        int         lat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_wr_i = 1'b0;
    logic [15:0] cmd_adr_i = '0;
    logic [7:0]  cmd_dat_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0;
    logic [7:0]  rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        cyc_o, stb_o, wr_o;
    logic [15:0] adr_o;
    logic [7:0]  dat_o, dat_i;
    logic        ack_i, err_i, rty_i;

    wishbone_single_master #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .wr_o(wr_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    int         p_wait [NATT];
    int         p_term [NATT];
    logic [7:0] p_dat  [NATT];
    logic        cur_wr;
    logic [15:0] cur_adr;
    logic [7:0]  cur_dat;

    int   att_idx = 0, att_cyc = 0, stb_total = 0, lat = 0, lat_first = 0;
    bit   in_att = 0, pending = 0, seen = 0, done = 0;
    logic [7:0] held_dat;
    logic [1:0] held_st;
    exp_t exp_q[$];

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Outcome of one command from the slave script: walk attempts, stop at the first final one.
    function automatic exp_t model(input logic wr);
        exp_t e;
        int gaps = 0;
        e.st = 2'd0; e.dat = 8'h00; e.stb = 0;
        for (int a = 0; a < NATT; a++) begin
            if (p_term[a] == T_NONE || p_wait[a] >= TO) begin
                e.stb += TO; e.st = 2'd2; break;
            end
            e.stb += p_wait[a] + 1;
            if (p_term[a] == T_ERR || p_term[a] == T_BOTH) begin
                e.st = 2'd1; break;
            end
            if (p_term[a] == T_ACK) begin
                e.st = 2'd0; e.dat = wr ? 8'h00 : p_dat[a]; break;
            end
            if (a == MR) begin
                e.st = 2'd3; break;
            end
            gaps++;
        end
        e.lat = e.stb + gaps + 1;
        return e;
    endfunction

    // Scripted slave; outside a strobe it drives random terminations that must be ignored.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 8'h00;
            in_att = 0;
        end else if (stb_o) begin
            if (!in_att) begin in_att = 1; att_cyc = 0; end
            else att_cyc++;
            stb_total++;
            chk("adr_o", int'(adr_o), int'(cur_adr));
            chk("dat_o", int'(dat_o), int'(cur_dat));
            chk("wr_o", int'(wr_o), int'(cur_wr));
            chk("cyc_o", int'(cyc_o), 1);
            chk("cmd_ready_busy", int'(cmd_ready_o), 0);
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 8'($urandom);
            if (att_idx < NATT && att_cyc == p_wait[att_idx]) begin
                case (p_term[att_idx])
                    T_ACK:  begin ack_i = 1'b1; dat_i = p_dat[att_idx]; end
                    T_ERR:  err_i = 1'b1;
                    T_RTY:  rty_i = 1'b1;
                    T_BOTH: begin ack_i = 1'b1; err_i = 1'b1; dat_i = p_dat[att_idx]; end
                    default: ;
                endcase
            end
        end else begin
            if (in_att) begin in_att = 0; att_idx++; end
            ack_i = 1'($urandom); err_i = 1'($urandom); rty_i = 1'($urandom);
            dat_i = 8'($urandom);
        end
    end

    // Response monitor: checks hold stability, then pops the scoreboard on handshake.
    always @(negedge clk_i) begin
        if (rst_n_i && pending) begin
            lat++;
            if (rsp_valid_o) begin
                if (!seen) begin
                    seen = 1; lat_first = lat;
                    held_dat = rsp_dat_o; held_st = rsp_status_o;
                end else begin
                    chk("rsp_dat_stable", int'(rsp_dat_o), int'(held_dat));
                    chk("rsp_status_stable", int'(rsp_status_o), int'(held_st));
                end
                chk("cmd_ready_resp", int'(cmd_ready_o), 0);
                chk("cyc_resp", int'(cyc_o), 0);
                if (rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_status", int'(rsp_status_o), int'(e.st));
                        chk("rsp_dat", int'(rsp_dat_o), int'(e.dat));
                        chk("stb_cycles", stb_total, e.stb);
                        chk("latency", lat_first, e.lat);
                    end
                    pending = 0; done = 1;
                end
            end
        end else if (rst_n_i && rsp_valid_o) begin
            chk("spurious_rsp_valid", 1, 0);
        end
    end

    task automatic set_att(input int i, input int w, input int t, input logic [7:0] d);
        p_wait[i] = w; p_term[i] = t; p_dat[i] = d;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NATT; i++) set_att(i, 0, T_NONE, 8'h00);
    endtask

    task automatic random_plan();
        for (int i = 0; i < NATT; i++) begin
            int r = int'($urandom_range(0, 99));
            int t = (r < 40) ? T_ACK : (r < 50) ? T_ERR : (r < 80) ? T_RTY : (r < 90) ? T_NONE : T_BOTH;
            set_att(i, int'($urandom_range(0, 5)), t, 8'($urandom));
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] adr, input logic [7:0] dat);
        chk("cmd_ready_idle", int'(cmd_ready_o), 1);
        cur_wr = wr; cur_adr = adr; cur_dat = dat;
        cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_adr_i = adr; cmd_dat_i = dat;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_wr_i = 1'($urandom);
        cmd_adr_i = 16'($urandom); cmd_dat_i = 8'($urandom);
        att_idx = 0; stb_total = 0;
    endtask

    // Full transaction; rsp_ready_i stays low for 'hold' cycles of valid response.
    task automatic run_cmd(input logic wr, input logic [15:0] adr, input logic [7:0] dat,
                           input int hold);
        exp_q.push_back(model(wr));
        rsp_ready_i = (hold == 0);
        issue(wr, adr, dat);
        lat = 0; seen = 0; done = 0; pending = 1;
        for (int k = 0; k < 200 && !rsp_valid_o; k++) begin
            @(posedge clk_i); #1;
        end
        if (!rsp_valid_o) begin
            chk("rsp_timeout", 0, 1);
            finish_run();
        end
        repeat (hold) @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        for (int k = 0; k < 10 && !done; k++) @(negedge clk_i);
        if (!done) begin
            chk("rsp_handshake", 0, 1);
            finish_run();
        end
        @(posedge clk_i); #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", int'(cmd_ready_o), 1);
        chk("rst_rsp_valid", int'(rsp_valid_o), 0);
        chk("rst_rsp_dat", int'(rsp_dat_o), 0);
        chk("rst_rsp_status", int'(rsp_status_o), 0);
        chk("rst_cyc", int'(cyc_o), 0);
        chk("rst_stb", int'(stb_o), 0);
        chk("rst_wr", int'(wr_o), 0);
        chk("rst_adr", int'(adr_o), 0);
        chk("rst_dat", int'(dat_o), 0);
    endtask

    initial begin
        #2 rst_n_i = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        clear_plan(); set_att(0, 0, T_ACK, 8'hFF);
        run_cmd(1'b0, 16'h1234, 8'h00, 0);
        clear_plan(); set_att(0, 3, T_ACK, 8'h77);
        run_cmd(1'b1, 16'h0010, 8'hA5, 0);
        clear_plan(); set_att(0, 1, T_BOTH, 8'h3C);
        run_cmd(1'b0, 16'h0BAD, 8'h00, 0);
        clear_plan();
        for (int i = 0; i < NATT; i++) set_att(i, 0, T_RTY, 8'h00);
        run_cmd(1'b0, 16'h2000, 8'h00, 0);
        clear_plan(); set_att(0, 0, T_RTY, 8'h00); set_att(1, 2, T_ACK, 8'h5A);
        run_cmd(1'b0, 16'h2001, 8'h00, 0);
        clear_plan();
        run_cmd(1'b1, 16'hDEAD, 8'h11, 0);
        clear_plan(); set_att(0, TO - 1, T_ACK, 8'hC3);
        run_cmd(1'b0, 16'h0042, 8'h00, 0);
        clear_plan(); set_att(0, 0, T_ACK, 8'h9E);
        run_cmd(1'b0, 16'h4321, 8'h00, 10);

        for (int n = 0; n < 150; n++) begin
            random_plan();
            run_cmd(1'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a bus phase: no response may follow.
        clear_plan();
        issue(1'b1, 16'hBEEF, 8'h66);
        @(posedge clk_i); #3;
        rst_n_i = 1'b0;
        #1 check_reset_vals();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (8) begin
            @(negedge clk_i);
            chk("post_reset_quiet", int'(rsp_valid_o | stb_o), 0);
        end
        @(posedge clk_i); #1;
        clear_plan(); set_att(0, 1, T_ACK, 8'h81);
        run_cmd(1'b0, 16'h0001, 8'h00, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        finish_run();
    end

    initial begin
        #2000000;
        chk("global_time_limit", 0, 1);
        finish_run();
    end
endmodule
